// File: rtl/gray2bin_stream.sv
// Handshaked Gray-to-binary decoder with a one-word output register.
// Also flags non-unit Gray steps, reports count direction and keeps a saturating error count.
module gray2bin_stream #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_gray,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bin,
    output logic                 out_first,
    output logic                 out_step_err,
    output logic                 out_dir_up,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] bin_c;
    logic [WIDTH-1:0] diff_c;
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] prev_bin;
    logic             hist_valid;
    logic             accept_c;
    logic             step_err_c;
    logic             dir_up_c;

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    always_comb begin
        bin_c = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_c[i] = ^(in_gray >> i);
        end
    end

    // A legal step changes exactly one Gray bit: the difference must be one-hot.
    always_comb begin
        diff_c     = in_gray ^ prev_gray;
        step_err_c = hist_valid &&
                     !((diff_c != '0) && ((diff_c & (diff_c - WIDTH'(1))) == '0));
        dir_up_c   = hist_valid && (bin_c == WIDTH'(prev_bin + WIDTH'(1)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_bin      <= '0;
            out_first    <= 1'b0;
            out_step_err <= 1'b0;
            out_dir_up   <= 1'b0;
            err_cnt      <= '0;
            hist_valid   <= 1'b0;
            prev_gray    <= '0;
            prev_bin     <= '0;
        end else if (accept_c) begin
            out_valid    <= 1'b1;
            out_bin      <= bin_c;
            out_first    <= !hist_valid;
            out_step_err <= step_err_c;
            out_dir_up   <= dir_up_c;
            if (step_err_c && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            hist_valid   <= 1'b1;
            prev_gray    <= in_gray;
            prev_bin     <= bin_c;
        end else if (out_ready) begin
            // Drained with nothing new: payload is left as is and ignored downstream.
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray2bin_stream.sv
// Self-checking bench for gray2bin_stream: directed plan scenarios plus randomized
// traffic against a value-level reference model (decode by search, popcount, modular add).
module tb_gray2bin_stream;

    localparam int unsigned W    = 4;
    localparam int unsigned EW   = 2;
    localparam int          NVAL = 1 << W;
    localparam int          CMAX = (1 << EW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_gray;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_bin;
    logic          out_first;
    logic          out_step_err;
    logic          out_dir_up;
    logic [EW-1:0] err_cnt;

    int n_cmp;
    int n_fail;

    // reference model state
    bit           m_valid;
    logic [W-1:0] m_bin;
    bit           m_first;
    bit           m_err;
    bit           m_up;
    int           m_cnt;
    bit           h_valid;
    logic [W-1:0] h_gray;
    int           h_bin;

    gray2bin_stream #(.WIDTH(W), .ERR_CNT_W(EW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_gray     (in_gray),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bin     (out_bin),
        .out_first   (out_first),
        .out_step_err(out_step_err),
        .out_dir_up  (out_dir_up),
        .err_cnt     (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] to_gray(input int v);
        logic [W-1:0] b;
        b = W'(v);
        return b ^ (b >> 1);
    endfunction

    // Find the binary value whose Gray code matches g.
    function automatic int decode(input logic [W-1:0] g);
        for (int v = 0; v < NVAL; v++) begin
            if (to_gray(v) == g) return v;
        end
        return -1;
    endfunction

    function automatic logic [W+EW+3:0] obs_vec();
        return {out_valid, out_bin, out_first, out_step_err, out_dir_up, err_cnt};
    endfunction

    function automatic logic [W+EW+3:0] exp_vec();
        return {1'(m_valid), m_bin, 1'(m_first), 1'(m_err), 1'(m_up), EW'(m_cnt)};
    endfunction

    function automatic bit exp_ready();
        return !m_valid || out_ready;
    endfunction

    task automatic drive(input bit v, input logic [W-1:0] g, input bit r);
        in_valid  = v;
        in_gray   = g;
        out_ready = r;
    endtask

    // Advance one clock and move the model by the same transfer.
    task automatic tick();
        bit acc;
        int b;
        acc = in_valid && exp_ready();
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_bin = '0; m_first = 0; m_err = 0; m_up = 0; m_cnt = 0;
            h_valid = 0; h_gray = '0; h_bin = 0;
        end else if (acc) begin
            b       = decode(in_gray);
            m_valid = 1;
            m_bin   = W'(b);
            m_first = !h_valid;
            m_err   = h_valid && ($countones(in_gray ^ h_gray) != 1);
            m_up    = h_valid && (b == (h_bin + 1) % NVAL);
            if (m_err && m_cnt < CMAX) m_cnt = m_cnt + 1;
            h_valid = 1;
            h_gray  = in_gray;
            h_bin   = b;
        end else if (out_ready) begin
            m_valid = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b1);
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 4'b1010, 1'b0);
        tick();
        tick();
        n_cmp++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] gs [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b1000};
        logic [W-1:0] bs [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b1111};
        bit fs [4] = '{1, 0, 0, 0};
        bit es [4] = '{0, 0, 0, 1};
        bit us [4] = '{0, 1, 1, 0};
        int cs [4] = '{0, 0, 0, 1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, gs[i], 1'b1);
            tick();
            n_cmp++;
            if (obs_vec() !== {1'b1, bs[i], 1'(fs[i]), 1'(es[i]), 1'(us[i]), EW'(cs[i])}) begin
                n_fail++;
                $display("FAIL basic[%0d]: got %h want %h", i, obs_vec(),
                         {1'b1, bs[i], 1'(fs[i]), 1'(es[i]), 1'(us[i]), EW'(cs[i])});
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i <= NVAL; i++) begin
            drive(1'b1, to_gray(i % NVAL), 1'b1);
            tick();
            n_cmp++;
            if (obs_vec() !== {1'b1, W'(i % NVAL), 1'(i == 0), 1'b0, 1'(i != 0), EW'(0)}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %h want %h", i, obs_vec(),
                         {1'b1, W'(i % NVAL), 1'(i == 0), 1'b0, 1'(i != 0), EW'(0)});
            end
        end
    endtask

    task automatic test_down();
        do_reset();
        for (int i = 5; i >= 3; i--) begin
            drive(1'b1, to_gray(i), 1'b1);
            tick();
            n_cmp++;
            if (obs_vec() !== {1'b1, W'(i), 1'(i == 5), 1'b0, 1'b0, EW'(0)}) begin
                n_fail++;
                $display("FAIL down[%0d]: got %h want %h", i, obs_vec(),
                         {1'b1, W'(i), 1'(i == 5), 1'b0, 1'b0, EW'(0)});
            end
        end
    endtask

    task automatic test_saturate();
        int cs [5] = '{0, 1, 2, 3, 3};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'b0000, 1'b1);
            tick();
            n_cmp++;
            if ({out_step_err, err_cnt} !== {1'(i != 0), EW'(cs[i])}) begin
                n_fail++;
                $display("FAIL saturate[%0d]: got err=%b cnt=%0d want err=%b cnt=%0d",
                         i, out_step_err, err_cnt, (i != 0), cs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, 4'b0110, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0111, 1'b0);
            #1;
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_ready[%0d]: got %b want 0", i, in_ready);
            end
            tick();
            n_cmp++;
            if ({out_valid, out_bin} !== {1'b1, 4'b0100}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b bin=%b want v=1 bin=0100",
                         i, out_valid, out_bin);
            end
        end
        drive(1'b1, 4'b0111, 1'b1);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_ready: got %b want 1", in_ready);
        end
        tick();
        n_cmp++;
        if (obs_vec() !== {1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, EW'(0)}) begin
            n_fail++;
            $display("FAIL release_word: got %h want %h", obs_vec(),
                     {1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, EW'(0)});
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b0000, i != 2);
            tick();
        end
        rst_n = 1'b0;
        drive(1'b0, 4'b0000, 1'b0);
        tick();
        n_cmp++;
        if (obs_vec() !== '0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %h want 0", obs_vec());
        end
        rst_n = 1'b1;
        drive(1'b1, 4'b1100, 1'b1);
        tick();
        n_cmp++;
        if (obs_vec() !== {1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, EW'(0)}) begin
            n_fail++;
            $display("FAIL midreset_first: got %h want %h", obs_vec(),
                     {1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, EW'(0)});
        end
    endtask

    task automatic test_random();
        logic [W-1:0] g;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       g = h_gray ^ W'(1 << $urandom_range(0, W - 1));
                1:       g = to_gray((h_bin + 1) % NVAL);
                2:       g = to_gray((h_bin + NVAL - 1) % NVAL);
                default: g = W'($urandom);
            endcase
            rst_n = ($urandom_range(0, 79) != 0);
            drive($urandom_range(0, 9) < 7, g, $urandom_range(0, 9) < 6);
            #1;
            n_cmp++;
            if (in_ready !== exp_ready()) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, exp_ready());
            end
            tick();
            n_cmp++;
            if (m_valid ? (obs_vec() !== exp_vec()) : (out_valid !== 1'b0)) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got %h want %h", n, obs_vec(), exp_vec());
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, '0, 1'b0);
        test_reset();
        test_basic();
        test_wrap();
        test_down();
        test_saturate();
        test_backpressure();
        test_midreset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
